hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage CPU.
- Decides per cycle whether to stall PC and IF/ID, inject a bubble into ID/EX, or flush on a taken branch.
- Tracks the multi-cycle multiply/divide unit (MDU) with an internal countdown, and stalls only instructions that need its result or the MDU itself.
- Sits beside the forwarding unit; it covers the cases forwarding cannot resolve (load-use, MDU busy, control flow).

---
 rtl/cpu_pipe_pkg.sv | 18 +
 rtl/mdu_timer.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline control logic.
//   hc_state_t   : hazard controller MDU tracking state
//   REG_ZERO     : architectural $0, never a hazard source
//   BYTE_EN_NONE : byte-enable pattern meaning "no register write"
package cpu_pipe_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned BE_W  = 4;

   localparam logic [REG_W-1:0] REG_ZERO     = 5'd0;
   localparam logic [BE_W-1:0]  BYTE_EN_NONE = 4'b0000;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MDU_RUN = 1'b1
   } hc_state_t;

endpackage : cpu_pipe_pkg

// File: rtl/mdu_timer.sv
// Countdown timer modelling the latency of the multi-cycle MDU.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle start pulse (ignored while running)
//   busy       : countdown active (forced low while rst_n is low)
//   done       : final busy cycle (count has reached zero)
module mdu_timer
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned MDU_CYCLES = 32,
   parameter int unsigned CNT_W      = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done
);

   hc_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: load MDU_CYCLES-1 on start, leave one cycle after zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = MDU_RUN;
               cnt_d   = CNT_W'(MDU_CYCLES - 1);
            end
         end
         MDU_RUN: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = rst_n & (state_q == MDU_RUN);
   assign done = busy & (cnt_q == '0);

endmodule : mdu_timer

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: stalls PC/IF-ID and bubbles
// ID/EX on load-use or MDU hazards, flushes on taken branches, and issues
// MDU start pulses. All control outputs are combinational, zero latency.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   id_*                 : register usage of the instruction in ID
//   idex_*               : destination / load info of the instruction in EX
//   ex_branch_taken      : EX resolved a taken branch or jump
//   pc_stall, ifid_stall : hold PC and IF/ID
//   ifid_flush           : clear IF/ID to a nop
//   idex_flush           : load a bubble into ID/EX
//   mdu_go, mdu_busy     : MDU start pulse and countdown-active flag
//   perf_stall_cnt, perf_flush_cnt : saturating event counters, present
//                          only when HAZARD_PERF_EN is defined
module hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned MDU_CYCLES = 32,
   parameter int unsigned CNT_W      = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs_addr,
   input  logic [REG_W-1:0] id_rt_addr,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_reads_hilo,
   input  logic             id_mdu_op,
   input  logic [REG_W-1:0] idex_rd_addr,
   input  logic [BE_W-1:0]  idex_byte_en,
   input  logic             idex_is_load,
   input  logic             ex_branch_taken,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             mdu_go,
   output logic             mdu_busy
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]      perf_stall_cnt,
   output logic [31:0]      perf_flush_cnt
`endif
);

   logic load_use;
   logic mdu_haz;
   logic mdu_done;

   mdu_timer #(
      .MDU_CYCLES (MDU_CYCLES),
      .CNT_W      (CNT_W)
   ) u_mdu_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mdu_go),
      .busy  (mdu_busy),
      .done  (mdu_done)
   );

   // Hazard detection; a load into $0 or with no byte enables writes nothing.
   always_comb begin
      load_use = idex_is_load
               & (idex_byte_en != BYTE_EN_NONE)
               & (idex_rd_addr != REG_ZERO)
               & ((id_uses_rs & (id_rs_addr == idex_rd_addr))
                | (id_uses_rt & (id_rt_addr == idex_rd_addr)));
      mdu_haz  = mdu_busy & (id_reads_hilo | id_mdu_op);
   end

   // Priority: flush beats stall (the stalled instruction is squashed anyway).
   always_comb begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      mdu_go     = 1'b0;
      if (rst_n) begin
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use || mdu_haz) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
         end else begin
            mdu_go     = id_mdu_op;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   // Saturating event counters.
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (pc_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (ifid_flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
         perf_flush_d = perf_flush_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

   // The countdown always ends in IDLE, and a new op never starts mid-run.
   a_done_ends_run : assert property (@(posedge clk) disable iff (!rst_n)
      mdu_done |=> !mdu_busy);
   a_no_go_when_busy : assert property (@(posedge clk) disable iff (!rst_n)
      !(mdu_go && mdu_busy));

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MDU_CYCLES=4. The driver applies one
// directed vector per cycle and queues its hand-computed expected outputs;
// the monitor pops and compares at each falling edge.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs_addr = '0, id_rt_addr = '0, idex_rd_addr = '0;
   logic       id_uses_rs = 0, id_uses_rt = 0, id_reads_hilo = 0, id_mdu_op = 0;
   logic [3:0] idex_byte_en = '0;
   logic       idex_is_load = 0, ex_branch_taken = 0;
   logic       pc_stall, ifid_stall, ifid_flush, idex_flush, mdu_go, mdu_busy;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      string      nm;
      logic [5:0] e;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(6)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs_addr      (id_rs_addr),
      .id_rt_addr      (id_rt_addr),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .id_reads_hilo   (id_reads_hilo),
      .id_mdu_op       (id_mdu_op),
      .idex_rd_addr    (idex_rd_addr),
      .idex_byte_en    (idex_byte_en),
      .idex_is_load    (idex_is_load),
      .ex_branch_taken (ex_branch_taken),
      .pc_stall        (pc_stall),
      .ifid_stall      (ifid_stall),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .mdu_go          (mdu_go),
      .mdu_busy        (mdu_busy)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   // Expected order: {pc_stall, ifid_stall, ifid_flush, idex_flush, mdu_go, mdu_busy}
   task automatic drv(input string nm, input logic rst,
                      input logic ld, input logic [4:0] rd, input logic [3:0] be,
                      input logic urs, input logic [4:0] rs,
                      input logic urt, input logic [4:0] rt,
                      input logic hilo, input logic mop, input logic br,
                      input logic [5:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n           = rst;
      idex_is_load    = ld;
      idex_rd_addr    = rd;
      idex_byte_en    = be;
      id_uses_rs      = urs;
      id_rs_addr      = rs;
      id_uses_rt      = urt;
      id_rt_addr      = rt;
      id_reads_hilo   = hilo;
      id_mdu_op       = mop;
      ex_branch_taken = br;
      x.nm = nm;
      x.e  = e;
      exp_q.push_back(x);
   endtask

   task automatic idle(input string nm, input logic [5:0] e);
      drv(nm, 1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 0, 0, e);
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] e);
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, e);
   endtask

   // Monitor: compare the DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t x;
         logic [5:0] act;
         x   = exp_q.pop_front();
         act = {pc_stall, ifid_stall, ifid_flush, idex_flush, mdu_go, mdu_busy};
         n_total++;
         if (act === x.e) n_pass++;
         else $display("FAIL %s: got %b expected %b", x.nm, act, x.e);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "timeout");
   end

   initial begin
      //        name            rst ld rd    be    urs rs    urt rt    hl mop br  expected
      drv("rst_gate",           0, 1, 5'd8, 4'hF, 1, 5'd8, 0, 5'd0, 0, 0, 0, 6'b000000);
      drv("lu_rs",              1, 1, 5'd8, 4'hF, 1, 5'd8, 0, 5'd0, 0, 0, 0, 6'b110100);
      idle("lu_clear",                                                      6'b000000);
      drv("lu_r0",              1, 1, 5'd0, 4'hF, 1, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000);
      drv("lu_rt",              1, 1, 5'd9, 4'h1, 0, 5'd0, 1, 5'd9, 0, 0, 0, 6'b110100);
      drv("lu_be0",             1, 1, 5'd9, 4'h0, 0, 5'd0, 1, 5'd9, 0, 0, 0, 6'b000000);
      drv("raw_fwd",            1, 0, 5'd8, 4'hF, 1, 5'd8, 0, 5'd0, 0, 0, 0, 6'b000000);
      drv("lu_nouse",           1, 1, 5'd8, 4'hF, 0, 5'd8, 0, 5'd0, 0, 0, 0, 6'b000000);
      drv("br_lu",              1, 1, 5'd8, 4'hF, 1, 5'd8, 0, 5'd0, 0, 0, 1, 6'b001100);
      // MDU op then mfhi stalled for the 4 busy cycles
      drv("mdu_go",             1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b000010);
      for (int i = 0; i < 4; i++)
         drv($sformatf("mfhi_stall%0d", i), 1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b110101);
      drv("mfhi_go",            1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b000000);
      // Back-to-back MDU ops; a branch mid-run flushes but keeps counting
      drv("mdu2_go1",           1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b000010);
      drv("mdu2_stall0",        1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b110101);
      drv("br_in_run",          1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 6'b001101);
      drv("mdu2_stall2",        1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b110101);
      drv("mdu2_stall3",        1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b110101);
      drv("mdu2_go2",           1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 6'b000010);
      idle("run_cnt3",                                                      6'b000001);
`ifdef HAZARD_PERF_EN
      chk32("perf_stall", perf_stall_cnt, 32'd9);
      chk32("perf_flush", perf_flush_cnt, 32'd2);
`endif
      // Reset while mdu_cnt=2: busy must drop before the next clock edge
      drv("rst_mid",            0, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b000000);
      drv("post_rst_mfhi",      1, 0, 5'd0, 4'h0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b000000);
`ifdef HAZARD_PERF_EN
      chk32("perf_stall_rst", perf_stall_cnt, 32'd0);
      chk32("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif
      idle("final_idle",                                                    6'b000000);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_hazard_ctrl
